// File: rtl/upd78_alu_pkg.sv
// Shared types for the uPD78-style ALU: operation encoding and iteration FSM states.
package upd78_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC, OP_AND, OP_OR,
    OP_XOR, OP_SHL, OP_RLC, OP_SHR, OP_RRC, OP_DAA, OP_MUL, OP_DIV
  } e_aluop;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } e_alust;

endpackage

// File: rtl/upd78_alu_iter.sv
// Bit-serial MUL (shift-add) / DIV (restoring) engine with its iteration counter.
// i_load is an already-accepted start qualified by CE; state only moves on CE edges.
module upd78_alu_iter
  import upd78_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_ce,
  input  logic         i_load,
  input  logic         i_div,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_fin,
  output logic         o_div,
  output logic         o_dz,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi,
  output e_alust       o_state
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  e_alust        r_state;
  e_alust        w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_op2;
  logic          r_dz;
  logic [W:0]    w_sum;
  logic [W:0]    w_shf;
  logic [W-1:0]  w_dif;
  logic          w_ge;
  logic [W-1:0]  w_hi_n;
  logic [W-1:0]  w_lo_n;
  logic          w_last;

  assign w_last = (r_cnt == CNT_ONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_state <= ST_IDLE;
    else if (i_ce) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:        if (i_load) w_next = i_div ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (w_last) w_next = ST_IDLE;
      default:        w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_state = r_state;
    o_busy  = (r_state != ST_IDLE);
    o_div   = (r_state == ST_DIV);
    o_fin   = i_ce && (r_state != ST_IDLE) && w_last;
    o_dz    = r_dz;
    o_lo    = r_dz ? '1   : w_lo_n;
    o_hi    = r_dz ? r_lo : w_hi_n;
  end

  // {r_hi,r_lo} is the shared product / remainder:quotient register pair.
  always_comb begin
    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op2} : '0);
    w_shf = {r_hi, r_lo[W-1]};
    w_ge  = (w_shf >= {1'b0, r_op2});
    w_dif = w_shf[W-1:0] - r_op2;
    if (r_state == ST_DIV) begin
      w_hi_n = w_ge ? w_dif : w_shf[W-1:0];
      w_lo_n = {r_lo[W-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[W:1];
      w_lo_n = {w_sum[0], r_lo[W-1:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_op2 <= '0;
      r_dz  <= 1'b0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_op2 <= i_b;
      r_dz  <= i_div && (i_b == '0);
      r_cnt <= (i_div && (i_b == '0)) ? CNT_ONE : CNT_FULL;
    end else if (i_ce && (r_state != ST_IDLE)) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/upd78_alu.sv
// uPD78-style ALU: single-cycle arithmetic/logic/shift/DAA plus an optional
// bit-serial MUL/DIV engine; all results land in registered outputs on CE edges.
module upd78_alu
  import upd78_alu_pkg::*;
#(
  parameter int W      = 8,
  parameter int MULDIV = 1
) (
  input  logic         CLK,
  input  logic         RESETB,
  input  logic         CE,
  input  logic         START,
  input  logic [3:0]   OP,
  input  logic [W-1:0] AI,
  input  logic [W-1:0] BI,
  input  logic         CI,
  input  logic         HCI,
  output logic [W-1:0] CO,
  output logic [W-1:0] CO_HI,
  output logic         CY,
  output logic         HC,
  output logic         Z,
  output logic         BUSY,
  output logic         DONE,
  output e_alust       o_dbg_state
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  e_aluop       w_op;
  logic         w_cin, w_md, w_acc;
  logic [W:0]   w_add, w_sub;
  logic         w_dlo, w_dhi;
  logic [7:0]   w_dadj, w_dsum;
  logic [W-1:0] w_co;
  logic         w_cy, w_hc, w_z;
  logic         w_busy, w_fin, w_it_div, w_it_dz;
  logic [W-1:0] w_it_lo, w_it_hi;
  logic [W-1:0] r_co, r_hi;
  logic         r_cy, r_hc, r_z, r_done;

  assign w_op  = e_aluop'(OP);
  assign w_md  = (MULDIV != 0) && ((w_op == OP_MUL) || (w_op == OP_DIV));
  assign w_acc = CE && START && !w_busy;

  always_comb begin
    w_cin  = ((w_op == OP_ADC) || (w_op == OP_SBB)) ? CI : 1'b0;
    w_add  = {1'b0, AI} + {1'b0, BI} + {{W{1'b0}}, w_cin};
    w_sub  = {1'b0, AI} - {1'b0, BI} - {{W{1'b0}}, w_cin};
    w_dlo  = HCI || (AI[3:0] > 4'd9);
    w_dhi  = CI || (AI[7:0] > 8'h99);
    w_dadj = {1'b0, w_dhi, w_dhi, 1'b0, 1'b0, w_dlo, w_dlo, 1'b0};
    w_dsum = AI[7:0] + w_dadj;
    w_co   = AI;
    w_cy   = r_cy;
    w_hc   = r_hc;
    case (w_op)
      OP_ADD, OP_ADC: begin
        w_co = w_add[W-1:0];
        w_cy = w_add[W];
        w_hc = ({1'b0, AI[3:0]} + {1'b0, BI[3:0]} + {4'b0, w_cin}) > 5'd15;
      end
      OP_SUB, OP_SBB: begin
        w_co = w_sub[W-1:0];
        w_cy = w_sub[W];
        w_hc = {1'b0, AI[3:0]} < ({1'b0, BI[3:0]} + {4'b0, w_cin});
      end
      OP_INC: begin w_co = AI + ONE; w_hc = (AI[3:0] == 4'hF); end
      OP_DEC: begin w_co = AI - ONE; w_hc = (AI[3:0] == 4'h0); end
      OP_AND: w_co = AI & BI;
      OP_OR:  w_co = AI | BI;
      OP_XOR: w_co = AI ^ BI;
      OP_SHL: begin w_co = {AI[W-2:0], 1'b0}; w_cy = AI[W-1]; end
      OP_RLC: begin w_co = {AI[W-2:0], CI};   w_cy = AI[W-1]; end
      OP_SHR: begin w_co = {1'b0, AI[W-1:1]}; w_cy = AI[0];   end
      OP_RRC: begin w_co = {CI, AI[W-1:1]};   w_cy = AI[0];   end
      OP_DAA: begin
        // Only the low byte is adjusted; upper bits of a 16-bit AI pass through.
        w_co[7:0] = w_dsum;
        w_cy      = CI | w_dhi;
        w_hc      = ({1'b0, AI[3:0]} + {1'b0, w_dadj[3:0]}) > 5'd15;
      end
      default: begin w_co = '0; w_cy = 1'b0; w_hc = 1'b0; end
    endcase
    w_z = (w_co == '0);
  end

  generate
    if (MULDIV != 0) begin : g_md
      upd78_alu_iter #(.W(W)) u_iter (
        .i_clk   (CLK),
        .i_rst_n (RESETB),
        .i_ce    (CE),
        .i_load  (w_acc && w_md),
        .i_div   (w_op == OP_DIV),
        .i_a     (AI),
        .i_b     (BI),
        .o_busy  (w_busy),
        .o_fin   (w_fin),
        .o_div   (w_it_div),
        .o_dz    (w_it_dz),
        .o_lo    (w_it_lo),
        .o_hi    (w_it_hi),
        .o_state (o_dbg_state)
      );
    end else begin : g_nomd
      assign w_busy      = 1'b0;
      assign w_fin       = 1'b0;
      assign w_it_div    = 1'b0;
      assign w_it_dz     = 1'b0;
      assign w_it_lo     = '0;
      assign w_it_hi     = '0;
      assign o_dbg_state = ST_IDLE;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_co   <= '0;
      r_hi   <= '0;
      r_cy   <= 1'b0;
      r_hc   <= 1'b0;
      r_z    <= 1'b0;
      r_done <= 1'b0;
    end else if (CE) begin
      r_done <= 1'b0;
      if (w_acc && !w_md) begin
        r_co   <= w_co;
        r_hi   <= '0;
        r_cy   <= w_cy;
        r_hc   <= w_hc;
        r_z    <= w_z;
        r_done <= 1'b1;
      end else if (w_fin) begin
        r_co   <= w_it_lo;
        r_hi   <= w_it_hi;
        r_hc   <= 1'b0;
        r_done <= 1'b1;
        if (w_it_div) begin
          r_cy <= w_it_dz;
          r_z  <= (w_it_lo == '0);
        end else begin
          r_cy <= (w_it_hi != '0);
          r_z  <= (w_it_lo == '0) && (w_it_hi == '0);
        end
      end
    end
  end

  assign CO    = r_co;
  assign CO_HI = r_hi;
  assign CY    = r_cy;
  assign HC    = r_hc;
  assign Z     = r_z;
  assign BUSY  = w_busy;
  assign DONE  = r_done;

endmodule
